// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin share of a single-port synchronous RAM between CPU (m0) and loader (m1).
// Define ARB_FIXED_PRIO_EN to make m0 win every tie instead of alternating.
module ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_cmd,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE_M0 = 2'd1, ISSUE_M1 = 2'd2;
    localparam logic [1:0] CMD_IDLE = 2'b00, CMD_RD = 2'b01, CMD_WR = 2'b10;

    logic [1:0] state, state_nxt;
    logic       elig0, elig1, pick1, sel_we, rd_pending, rd_owner;

    // A requester that was granted last cycle still shows req; masking it avoids a double issue
    assign elig0 = m0_req & ~m0_gnt;
    assign elig1 = m1_req & ~m1_gnt;
`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = elig1 & ~elig0;
`else
    logic last_winner;
    assign pick1 = elig1 & (~elig0 | ~last_winner);
`endif
    assign sel_we    = pick1 ? m1_we : m0_we;
    assign state_nxt = (elig0 | elig1) ? (pick1 ? ISSUE_M1 : ISSUE_M0) : IDLE;

    assign m0_gnt    = state == ISSUE_M0;
    assign m1_gnt    = state == ISSUE_M1;
    assign busy      = ram_cmd != CMD_IDLE;
    assign m0_rvalid = rd_pending & ~rd_owner;
    assign m1_rvalid = rd_pending & rd_owner;
    assign m0_rdata  = m0_rvalid ? ram_r_data : '0;
    assign m1_rdata  = m1_rvalid ? ram_r_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ram_addr   <= '0;
            ram_cmd    <= CMD_IDLE;
            ram_w_data <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ram_cmd    <= (state_nxt == IDLE) ? CMD_IDLE : (sel_we ? CMD_WR : CMD_RD);
            // The RAM returns data one cycle after the read command, so one tracking slot suffices
            rd_pending <= ram_cmd == CMD_RD;
            rd_owner   <= m1_gnt;
            if (state_nxt != IDLE) begin
                ram_addr <= pick1 ? m1_addr : m0_addr;
                if (sel_we) ram_w_data <= pick1 ? m1_wdata : m0_wdata;
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_winner <= 1'b1;
        else if (state_nxt != IDLE) last_winner <= pick1;
    end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter with a behavioural RAM and per-master read scoreboards.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [8:0]  m0_addr, m1_addr, ram_addr;
    logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_w_data, ram_r_data;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, busy;
    logic [1:0]  ram_cmd;
    logic [15:0] mem [512];
    logic        written [512];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    int          total = 0;
    int          bad = 0;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_cmd(ram_cmd), .ram_w_data(ram_w_data),
        .ram_r_data(ram_r_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [8:0] a);
        return (a == 9'h005) ? 16'hBEEF : {7'd0, a};
    endfunction

    // Unwritten locations return a fixed address-derived pattern
    always @(posedge clk) begin
        if (ram_cmd == 2'b10) begin
            mem[ram_addr]     <= ram_w_data;
            written[ram_addr] <= 1'b1;
        end
        if (ram_cmd == 2'b01)
            ram_r_data <= (written[ram_addr] === 1'b1) ? mem[ram_addr] : init_val(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #2;
        if (m0_rvalid) begin
            if (q0.size() == 0) chk("m0_unexpected_rvalid", 1, 0);
            else chk("m0_rdata", m0_rdata, q0.pop_front());
            chk("m1_rdata_nonowner", m1_rdata, 0);
        end
        if (m1_rvalid) begin
            if (q1.size() == 0) chk("m1_unexpected_rvalid", 1, 0);
            else chk("m1_rdata", m1_rdata, q1.pop_front());
            chk("m0_rdata_nonowner", m0_rdata, 0);
        end
    end

    initial begin
        rst_n = 1'b0;
        {m0_req, m0_we, m1_req, m1_we} = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd", ram_cmd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_w_data, 0);
        rst_n = 1'b1;

        // read granted, then reset before the data returns
        m0_addr = 9'h010; m0_req = 1'b1;
        step();
        chk("midrd_gnt", m0_gnt, 1);
        chk("midrd_cmd", ram_cmd, 1);
        m0_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrd_rst_cmd", ram_cmd, 0);
        chk("midrd_rst_busy", busy, 0);
        step();
        chk("midrd_no_rvalid", m0_rvalid, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("midrd_no_rvalid2", m0_rvalid, 0);

        // single m0 read
        m0_addr = 9'h005; m0_req = 1'b1;
        step();
        chk("rd_gnt", m0_gnt, 1);
        chk("rd_m1_gnt", m1_gnt, 0);
        chk("rd_cmd", ram_cmd, 1);
        chk("rd_addr", ram_addr, 9'h005);
        q0.push_back(16'hBEEF);
        m0_req = 1'b0;
        step();
        chk("rd_rvalid", m0_rvalid, 1);
        chk("rd_m1_rvalid", m1_rvalid, 0);

        // m1 write then m0 read-back
        m1_addr = 9'h0A0; m1_wdata = 16'h1234; m1_we = 1'b1; m1_req = 1'b1;
        step();
        chk("wr_gnt", m1_gnt, 1);
        chk("wr_cmd", ram_cmd, 2);
        chk("wr_addr", ram_addr, 9'h0A0);
        chk("wr_data", ram_w_data, 16'h1234);
        chk("wr_busy", busy, 1);
        m1_req = 1'b0; m1_we = 1'b0;
        m0_addr = 9'h0A0; m0_req = 1'b1;
        step();
        chk("wr_no_m1_rvalid", m1_rvalid, 0);
        chk("rb_gnt", m0_gnt, 1);
        chk("rb_wdata_hold", ram_w_data, 16'h1234);
        q0.push_back(16'h1234);
        m0_req = 1'b0;
        step();
        chk("rb_rvalid", m0_rvalid, 1);
        step();

        // tie from reset: m0 first, then alternate every cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m0_addr = 9'h001; m1_addr = 9'h002; m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tie_m0_gnt", m0_gnt, (i % 2 == 0));
            chk("tie_m1_gnt", m1_gnt, (i % 2 != 0));
            chk("tie_cmd", ram_cmd, 1);
            chk("tie_addr", ram_addr, (i % 2 == 0) ? 9'h001 : 9'h002);
            if (i % 2 == 0) q0.push_back(16'h0001);
            else q1.push_back(16'h0002);
            if (i == 3) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
        end
        step();
        step();

        // lone m0 is masked every other cycle
        m0_addr = 9'h005; m0_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mask_m0_gnt", m0_gnt, (i % 2 == 0));
            chk("mask_cmd", ram_cmd, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) q0.push_back(16'hBEEF);
            if (i == 5) m0_req = 1'b0;
        end
        step();
        step();

        // lone m1 streams on every eligible cycle
        m1_addr = 9'h002; m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("m1only_gnt", m1_gnt, (i % 2 == 0));
            chk("m1only_m0_gnt", m0_gnt, 0);
            if (i % 2 == 0) q1.push_back(16'h0002);
            if (i == 3) m1_req = 1'b0;
        end
        step();
        step();
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port synchronous RAM between two requesters:
  - m0: the CPU memory port.
  - m1: the program loader / debug port that fills or inspects RAM from switches/keys.
- Registered round-robin arbitration, one RAM command per cycle, fixed read-return latency.
- Sits between the cpu/loader and the RAM instance at the top level.

Parameters:
ADDR_W, 9, RAM word-address width
DATA_W, 16, RAM data width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  m0 access request, held until m0_gnt seen
m0_we  input  1  m0 access is write (1) / read (0)
m0_addr  input  ADDR_W  m0 word address
m0_wdata  input  DATA_W  m0 write data
m0_gnt  output  1  one-cycle pulse: m0 access issued to RAM this cycle
m0_rvalid  output  1  one-cycle pulse: m0_rdata valid
m0_rdata  output  DATA_W  m0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for m1
ram_addr  output  ADDR_W  registered RAM address
ram_cmd  output  2  registered RAM command: 2'b00 idle, 2'b01 read, 2'b10 write; 2'b11 never driven
ram_w_data  output  DATA_W  registered RAM write data
ram_r_data  input  DATA_W  RAM read data, valid the cycle after a read command
busy  output  1  ram_cmd != idle this cycle

Behaviour:
- Reset (async, rst_n=0):
  - ram_cmd=00, ram_addr=0, ram_w_data=0.
  - All gnt/rvalid=0, busy=0.
  - last_winner=m1, so m0 wins the first tie.
  - Pending read returns are discarded; no rvalid is produced after reset deasserts.
- Eligibility: mX is eligible at edge E if mX_req=1 and mX_gnt=0 in the cycle before E.
  - Masking prevents a double issue while the requester is still reacting to its grant.
- Arbitration at each edge:
  - Neither eligible: ram_cmd<=00, gnts<=0.
  - One eligible: that one wins.
  - Both eligible: winner = requester that is not last_winner; last_winner<=winner.
- Issue, in the cycle after the edge:
  - ram_addr<=winner addr; ram_cmd<=01 if we=0, else 10; ram_w_data<=winner wdata.
  - winner gnt=1 for exactly that cycle.
  - If we=0, ram_w_data holds its previous value.
- Latency:
  - Request sampled at edge E → gnt and RAM command in cycle E+1.
  - Read data arrives on ram_r_data in cycle E+2.
  - mX_rvalid=1 in cycle E+2; mX_rdata=ram_r_data, combinational pass-through.
- Read-return tracking:
  - rd_owner/rd_pending is registered at issue; exactly one pipeline slot is needed.
  - Non-owner rdata=0, rvalid=0.
- Writes: no rvalid; gnt marks completion.
- Throughput:
  - Alternating requesters: one command every cycle.
  - A single requester: at most one command per 2 cycles, because of masking.
- Requester rules: addr/we/wdata held stable while req=1 and gnt not yet seen; req may drop only after gnt.
- Simultaneous cases:
  - A read return for one master and a grant to the other in the same cycle are both legal.
  - Back-to-back reads from alternating masters return in issue order.
- FSM per cycle: IDLE (cmd 00), ISSUE_M0, ISSUE_M1. Next state follows the arbitration rule above.

Optional Feature:
- ARB_FIXED_PRIO_EN:
  - Defined: m0 always wins when both are eligible; last_winner is unused. m1 is served only in cycles where m0 is ineligible; m0 masking still guarantees m1 at least every other cycle while m0 streams.
  - Undefined: round-robin as above.

Test Plan:
- Reset mid-read: m0 read addr 9'h010 granted, rst_n pulled low before return → no m0_rvalid; ram_cmd=00, busy=0 immediately.
- Single m0 read: RAM[9'h005]=16'hBEEF, m0_req with we=0, addr 5 at edge E → m0_gnt and ram_cmd=01, ram_addr=5 at E+1; m0_rvalid=1, m0_rdata=16'hBEEF at E+2; m1_rvalid=0.
- m1 write then m0 read: m1 writes 16'h1234 to 9'h0A0, then m0 reads 9'h0A0 → m1_gnt with ram_cmd=10, ram_w_data=16'h1234; m0 later reads 16'h1234.
- Tie, round-robin: both hold continuous read requests (m0 addr 1, m1 addr 2) from reset → issues m0,m1,m0,m1 on consecutive cycles; rdata 1,2,1,2 returned to the correct owners.
- Masking: only m0_req held high for 6 cycles → m0_gnt pulses every other cycle (3 pulses); ram_cmd alternates 01/00.
- ARB_FIXED_PRIO_EN defined, same tie stimulus → m0 wins every tie; m1 granted only in m0-masked cycles; sequence m0,m1,m0,m1; with m0_req dropped, m1 gets consecutive-eligible grants.
